// File: rtl/video_timing_pkg.sv
// Shared timing defaults, pattern selector and FSM encodings for the video timing source.
package video_timing_pkg;

    // 640x480@60 raster defaults
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned DEF_CHK_LOG2 = 5;
    localparam int unsigned DEF_LC_BASE  = 96;
    localparam int unsigned DEF_LC_SHIFT = 3;

    typedef enum logic [1:0] {
        PAT_HRAMP = 2'd0,
        PAT_VRAMP = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_LOWC  = 2'd3
    } pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/video_pattern_gen.sv
// Combinational luma test-pattern source: pixel coordinate and selector in, 8-bit luma out.
module video_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned XW       = 10,
    parameter int unsigned YW       = 10,
    parameter int unsigned CHK_LOG2 = DEF_CHK_LOG2,
    parameter int unsigned LC_BASE  = DEF_LC_BASE,
    parameter int unsigned LC_SHIFT = DEF_LC_SHIFT
) (
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    input  pattern_e      sel_i,
    output logic [7:0]    luma_o
);

    logic       chk_x;
    logic       chk_y;
    logic [5:0] lc_off;

    always_comb begin
        // Shift-then-cast keeps the bit picks legal even when the coordinate is narrower than the pick
        chk_x  = 1'(x_i >> CHK_LOG2);
        chk_y  = 1'(y_i >> CHK_LOG2);
        lc_off = 6'(x_i >> LC_SHIFT);
        luma_o = '0;
        case (sel_i)
            PAT_HRAMP: luma_o = 8'(x_i);
            PAT_VRAMP: luma_o = 8'(y_i);
            PAT_CHECK: luma_o = (chk_x ^ chk_y) ? 8'hFF : 8'h00;
            PAT_LOWC:  luma_o = 8'(LC_BASE) + 8'(lc_off);
            default:   luma_o = '0;
        endcase
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source: counters, run/drain FSM and registered sync/blank/luma outputs.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    // _W suffix keeps the pulse widths distinct from the H_SYNC/V_SYNC port names
    parameter int unsigned H_SYNC_W = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC_W = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned CHK_LOG2 = DEF_CHK_LOG2,
    parameter int unsigned LC_BASE  = DEF_LC_BASE,
    parameter int unsigned LC_SHIFT = DEF_LC_SHIFT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [1:0] i_pattern_sel,
    output logic       H_SYNC,
    output logic       V_SYNC,
    output logic       BLANK,
    output logic [7:0] Y0,
    output logic       o_frame_start,
    output logic       o_busy
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC_W + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC_W + V_BP;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC_W;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC_W;

    state_e        state_q, state_d;
    pattern_e      pat_q, pat_d, pat_use;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          blank_q, blank_d;
    logic [7:0]    y_q, y_d;
    logic          fs_q, fs_d;
    logic          busy_q, busy_d;

    logic          running;
    logic          at_origin;
    logic          line_end;
    logic          frame_end;
    logic [7:0]    luma;

    video_pattern_gen #(
        .XW       (HW),
        .YW       (VW),
        .CHK_LOG2 (CHK_LOG2),
        .LC_BASE  (LC_BASE),
        .LC_SHIFT (LC_SHIFT)
    ) u_pattern (
        .x_i    (h_q),
        .y_i    (v_q),
        .sel_i  (pat_use),
        .luma_o (luma)
    );

    always_comb begin
        running   = (state_q != ST_IDLE);
        at_origin = (h_q == '0) && (v_q == '0);
        line_end  = (32'(h_q) == H_TOTAL - 1);
        frame_end = line_end && (32'(v_q) == V_TOTAL - 1);
        // The selector sampled at (0,0) must already drive that first pixel
        pat_use   = (state_q == ST_RUN && at_origin) ? pattern_e'(i_pattern_sel) : pat_q;

        state_d = state_q;
        pat_d   = pat_q;
        case (state_q)
            ST_IDLE: begin
                if (i_en) begin
                    state_d = ST_RUN;
                    pat_d   = pattern_e'(i_pattern_sel);
                end
            end
            ST_RUN: begin
                pat_d = pat_use;
                if (!i_en) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (i_en)           state_d = ST_RUN;
                else if (frame_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        h_d = h_q;
        v_d = v_q;
        if (running) begin
            if (line_end) begin
                h_d = '0;
                v_d = frame_end ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
            end
        end

        hsync_d = !(running && 32'(h_q) >= HS_START && 32'(h_q) < HS_END);
        vsync_d = !(running && 32'(v_q) >= VS_START && 32'(v_q) < VS_END);
        blank_d = running && (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
        y_d     = blank_d ? luma : '0;
        fs_d    = running && at_origin;
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pat_q   <= PAT_HRAMP;
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            blank_q <= 1'b0;
            y_q     <= '0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            blank_q <= blank_d;
            y_q     <= y_d;
            fs_q    <= fs_d;
            busy_q  <= busy_d;
        end
    end

    assign H_SYNC        = hsync_q;
    assign V_SYNC        = vsync_q;
    assign BLANK         = blank_q;
    assign Y0            = y_q;
    assign o_frame_start = fs_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 16x8 raster (8/2/3/3 by 4/1/2/1, 2-pixel checker).
module tb_video_timing_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_en;
    logic [1:0] i_pattern_sel;
    logic       H_SYNC;
    logic       V_SYNC;
    logic       BLANK;
    logic [7:0] Y0;
    logic       o_frame_start;
    logic       o_busy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC_W (3),
        .H_BP     (3),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC_W (2),
        .V_BP     (1),
        .CHK_LOG2 (1),
        .LC_BASE  (96),
        .LC_SHIFT (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_en          (i_en),
        .i_pattern_sel (i_pattern_sel),
        .H_SYNC        (H_SYNC),
        .V_SYNC        (V_SYNC),
        .BLANK         (BLANK),
        .Y0            (Y0),
        .o_frame_start (o_frame_start),
        .o_busy        (o_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag, input logic exp_busy);
        check({tag, " hsync"}, 32'(H_SYNC), 32'd1);
        check({tag, " vsync"}, 32'(V_SYNC), 32'd1);
        check({tag, " blank"}, 32'(BLANK), 32'd0);
        check({tag, " y0"},    32'(Y0), 32'd0);
        check({tag, " fs"},    32'(o_frame_start), 32'd0);
        check({tag, " busy"},  32'(o_busy), 32'(exp_busy));
    endtask

    // Hand tables: checker row for y[1]=0 is 0,0,255,255,0,0,255,255
    function automatic logic [7:0] exp_luma(input int pat, input int h, input int v);
        logic [7:0] row;
        row = 8'b1100_1100;
        case (pat)
            0:       return 8'(h);
            1:       return 8'(v);
            2:       return (row[h[2:0]] ^ (v >= 2)) ? 8'd255 : 8'd0;
            default: return 8'd96;
        endcase
    endfunction

    task automatic run_frame(input int f, input int pat, input int sel_p, input logic [1:0] new_sel,
                             input int off_p, input int on_p, input int rst_p);
        int   n_blank;
        int   n_vs;
        int   vs_first;
        int   h;
        int   v;
        logic eb;
        logic ending;
        n_blank  = 0;
        n_vs     = 0;
        vs_first = -1;
        ending   = (off_p >= 0) && (on_p < 0);
        for (int p = 0; p < 128; p++) begin
            if (p == sel_p) i_pattern_sel = new_sel;
            if (p == off_p) i_en = 1'b0;
            if (p == on_p)  i_en = 1'b1;
            if (p == rst_p) begin
                rst_n = 1'b0;
                step();
                check_quiet($sformatf("f%0d midreset", f), 1'b0);
                return;
            end
            step();
            h  = p % 16;
            v  = p / 16;
            eb = (v < 4) && (h < 8);
            check($sformatf("f%0d p%0d blank", f, p), 32'(BLANK), 32'(eb));
            check($sformatf("f%0d p%0d hsync", f, p), 32'(H_SYNC), 32'(!(h >= 10 && h <= 12)));
            check($sformatf("f%0d p%0d vsync", f, p), 32'(V_SYNC), 32'(!(v == 5 || v == 6)));
            check($sformatf("f%0d p%0d y0", f, p), 32'(Y0), eb ? 32'(exp_luma(pat, h, v)) : 32'd0);
            check($sformatf("f%0d p%0d fs", f, p), 32'(o_frame_start), 32'(p == 0));
            check($sformatf("f%0d p%0d busy", f, p), 32'(o_busy), 32'(!(ending && p == 127)));
            if (BLANK === 1'b1) n_blank++;
            if (V_SYNC === 1'b0) begin
                if (vs_first < 0) vs_first = p;
                n_vs++;
            end
        end
        check($sformatf("f%0d blank_count", f), 32'(n_blank), 32'd32);
        check($sformatf("f%0d vsync_len", f), 32'(n_vs), 32'd32);
        check($sformatf("f%0d vsync_start", f), 32'(vs_first), 32'd80);
    endtask

    initial begin
        rst_n         = 1'b0;
        i_en          = 1'b1;
        i_pattern_sel = 2'd0;

        for (int i = 0; i < 3; i++) begin
            step();
            check_quiet($sformatf("reset c%0d", i), 1'b0);
        end
        rst_n = 1'b1;

        step();
        check_quiet("entry", 1'b1);

        // Mid-frame selector changes only show up in the following frame
        run_frame(1, 0, 20, 2'd2, -1, -1, -1);
        run_frame(2, 2, 20, 2'd3, -1, -1, -1);
        run_frame(3, 3, 20, 2'd1, -1, -1, -1);
        run_frame(4, 1, 20, 2'd0, 40, -1, -1);

        for (int i = 0; i < 4; i++) begin
            step();
            check_quiet($sformatf("idle c%0d", i), 1'b0);
        end

        i_pattern_sel = 2'd2;
        i_en          = 1'b1;
        step();
        check_quiet("reentry", 1'b1);

        run_frame(5, 2, -1, 2'd2, 40, 60, -1);
        run_frame(6, 2, -1, 2'd2, 40, 127, -1);
        run_frame(7, 2, -1, 2'd2, -1, -1, 50);

        step();
        check_quiet("hold reset", 1'b0);
        rst_n = 1'b1;
        step();
        check("post reset entry fs", 32'(o_frame_start), 32'd0);
        check("post reset entry busy", 32'(o_busy), 32'd1);
        step();
        check("post reset fs", 32'(o_frame_start), 32'd1);
        check("post reset blank", 32'(BLANK), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
